// File: rtl/ins_fetch_sequencer.sv
// ins_fetch_sequencer
//   Fetch/issue sequencer placed between the UART-loaded instruction memory
//   and control_unit. A program counter walks instruction memory. Each 16-bit
//   word is split into opcode/operand1/operand2 and handed to control_unit
//   with a one-cycle en pulse. The instruction is then held for EXEC_CYC
//   cycles, after which the sequencer advances, jumps or halts.
//
// Parameters
//   PC_W      program counter / imem address width
//   EXEC_CYC  cycles spent in EXEC after issue (>= 1)
//   HALT_OP   opcode that stops the sequencer
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 level: begin/resume from IDLE or HALT
//   halt_req              level: sampled in the last EXEC cycle only
//   imem_addr, imem_rd    instruction fetch request (one-cycle strobe)
//   imem_data, imem_valid fetch response {opcode[15:8], op1[7:4], op2[3:0]}
//   dp_busy               datapath not ready; blocks issue
//   jump_en, jump_addr    sampled in the last EXEC cycle: pc <= jump_addr
//   addr_ins, operand1,
//   operand2, en          registered instruction fields and issue pulse
//   pc, halted            program counter, high while in HALT
//   step                  (SINGLE_STEP_EN only) rising edge releases PAUSE
//
// Configuration
//   SINGLE_STEP_EN  when defined, adds the step input and a PAUSE state that
//                   is entered at the end of every instruction without halt_req.

module ins_fetch_sequencer #(
  parameter int          PC_W     = 8,
  parameter int          EXEC_CYC = 2,
  parameter logic [7:0]  HALT_OP  = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            start,
  input  logic            halt_req,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     imem_data,
  input  logic            imem_valid,
  input  logic            dp_busy,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic [7:0]      addr_ins,
  output logic [3:0]      operand1,
  output logic [3:0]      operand2,
  output logic            en,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALT
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam int CNT_W = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;

  state_t           state;
  logic [CNT_W-1:0] exec_cnt;
  logic             exec_last;
  logic [PC_W-1:0]  pc_next;

`ifdef SINGLE_STEP_EN
  logic             step_q;
`endif

  assign exec_last = (exec_cnt == CNT_W'(EXEC_CYC - 1));
  // Sequential increment wraps naturally at 2^PC_W.
  assign pc_next   = jump_en ? jump_addr : (pc + PC_W'(1));

  // imem_rd and imem_addr are set on entry to FETCH, so the strobe is high
  // for exactly the one cycle the FSM spends in FETCH. en is likewise set on
  // the ISSUE->EXEC transition and is therefore visible in the first EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      exec_cnt  <= '0;
      pc        <= '0;
      imem_addr <= '0;
      imem_rd   <= 1'b0;
      addr_ins  <= '0;
      operand1  <= '0;
      operand2  <= '0;
      en        <= 1'b0;
      halted    <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      imem_rd <= 1'b0;
      en      <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q  <= step;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            imem_rd   <= 1'b1;
            imem_addr <= pc;
          end
        end

        S_FETCH: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (imem_valid) begin
            addr_ins <= imem_data[15:8];
            operand1 <= imem_data[7:4];
            operand2 <= imem_data[3:0];
            if (imem_data[15:8] == HALT_OP) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state  <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (!dp_busy) begin
            en       <= 1'b1;
            exec_cnt <= '0;
            state    <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (exec_last) begin
            // Jump and halt can coincide: the jump target is still loaded,
            // so a later resume starts there.
            pc <= pc_next;
            if (halt_req) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
`ifdef SINGLE_STEP_EN
              state     <= S_PAUSE;
`else
              state     <= S_FETCH;
              imem_rd   <= 1'b1;
              imem_addr <= pc_next;
`endif
            end
          end else begin
            exec_cnt <= exec_cnt + CNT_W'(1);
          end
        end

        S_HALT: begin
          if (start) begin
            state     <= S_FETCH;
            halted    <= 1'b0;
            imem_rd   <= 1'b1;
            imem_addr <= pc;
          end
        end

`ifdef SINGLE_STEP_EN
        S_PAUSE: begin
          if (halt_req) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (step && !step_q) begin
            state     <= S_FETCH;
            imem_rd   <= 1'b1;
            imem_addr <= pc;
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_sequencer.sv
// Testbench for ins_fetch_sequencer: a behavioural instruction memory with
// configurable latency, plus fetch-address and issued-instruction
// scoreboards that are compared whenever the DUT strobes imem_rd or en.
module tb_ins_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_valid = 1'b0;
  logic        dp_busy = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic [7:0]  addr_ins;
  logic [3:0]  operand1;
  logic [3:0]  operand2;
  logic        en;
  logic [7:0]  pc;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  always #5 clk = ~clk;

  ins_fetch_sequencer #(.PC_W(8), .EXEC_CYC(2), .HALT_OP(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SINGLE_STEP_EN
    .step       (step),
`endif
    .start      (start),
    .halt_req   (halt_req),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .dp_busy    (dp_busy),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .addr_ins   (addr_ins),
    .operand1   (operand1),
    .operand2   (operand2),
    .en         (en),
    .pc         (pc),
    .halted     (halted)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] mem [0:255];
  int          mem_lat  = 1;
  int          pend     = 0;
  logic [7:0]  pend_addr = 8'h00;
  logic [7:0]  fetch_q [$];
  logic [15:0] issue_q [$];
  int          en_cyc  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: answers mem_lat cycles after the strobe cycle.
  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        imem_valid = 1'b1;
        imem_data  = mem[pend_addr];
      end
    end
    if (imem_rd) begin
      pend      = mem_lat;
      pend_addr = imem_addr;
    end
  end

  // Monitor: pop and compare scoreboard entries on every fetch and issue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_rd) begin
        $display("fetch  addr=0x%02h  pc=0x%02h", imem_addr, pc);
        if (fetch_q.size() == 0) check("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
        else                     check("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
      end
      if (en) begin
        $display("issue  op=0x%02h op1=0x%0h op2=0x%0h", addr_ins, operand1, operand2);
        en_cyc.push_back(cyc);
        if (issue_q.size() == 0) check("issue_unexpected", 32'({addr_ins, operand1, operand2}), 32'hFFFF_FFFF);
        else                     check("issue_fields", 32'({addr_ins, operand1, operand2}), 32'(issue_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = 16'hFF00;
  endtask

  task automatic wait_en();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("en_timeout", 32'(en), 32'h1);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 200; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    check("halted", 32'(halted), 32'h1);
  endtask

  task automatic end_test(input string name);
    repeat (4) @(negedge clk);
    check({name, "_fetch_q_empty"}, 32'(fetch_q.size()), 32'h0);
    check({name, "_issue_q_empty"}, 32'(issue_q.size()), 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pc"},       32'(pc),        32'h0);
    check({name, "_addr_ins"}, 32'(addr_ins),  32'h0);
    check({name, "_operand1"}, 32'(operand1),  32'h0);
    check({name, "_operand2"}, 32'(operand2),  32'h0);
    check({name, "_imem_addr"},32'(imem_addr), 32'h0);
    check({name, "_imem_rd"},  32'(imem_rd),   32'h0);
    check({name, "_en"},       32'(en),        32'h0);
    check({name, "_halted"},   32'(halted),    32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: basic program, halt on HALT_OP, instruction period
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    load_default();
    mem[0] = 16'h0134; mem[1] = 16'h0256; mem[2] = 16'hFF00;
    fetch_q = '{8'h00, 8'h01, 8'h02};
    issue_q = '{16'h0134, 16'h0256};
    en_cyc.delete();
    pulse_start();
    wait_halt();
    check("t1_pc", 32'(pc), 32'h2);
    check("t1_halt_opcode", 32'(addr_ins), 32'hFF);
    if (en_cyc.size() == 2) check("t1_period", 32'(en_cyc[1] - en_cyc[0]), 32'd5);
    else                    check("t1_en_count", 32'(en_cyc.size()), 32'd2);
    end_test("t1");

    // Test 2: dp_busy holds the instruction in ISSUE
    do_reset();
    load_default();
    mem[0] = 16'h0A12;
    fetch_q = '{8'h00, 8'h01};
    issue_q = '{16'h0A12};
    dp_busy = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (addr_ins == 8'h0A) break;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check("t2_en_blocked", 32'(en), 32'h0);
      check("t2_fields_stable", 32'({addr_ins, operand1, operand2}), 32'h0A12);
      @(negedge clk);
    end
    dp_busy = 1'b0;
    @(negedge clk);
    check("t2_en_after_busy", 32'(en), 32'h1);
    wait_halt();
    end_test("t2");

    // Test 3: jump in last EXEC cycle taken; jump in first EXEC cycle ignored
    do_reset();
    load_default();
    mem[0] = 16'h0111; mem[8'h40] = 16'h0240;
    fetch_q = '{8'h00, 8'h40, 8'h41};
    issue_q = '{16'h0111, 16'h0240};
    pulse_start();
    wait_en();
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 8'h40;
    @(negedge clk);
    jump_en = 1'b0;
    wait_en();
    jump_en = 1'b1; jump_addr = 8'h80;
    @(negedge clk);
    jump_en = 1'b0;
    wait_halt();
    check("t3_pc", 32'(pc), 32'h41);
    end_test("t3");

    // Test 4: pc wraps from 0xFF to 0x00; halt_req in last EXEC cycle
    do_reset();
    load_default();
    mem[0] = 16'h0500; mem[8'hFF] = 16'h0300;
    fetch_q = '{8'h00, 8'hFF, 8'h00};
    issue_q = '{16'h0500, 16'h0300, 16'h0500};
    pulse_start();
    wait_en();
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 8'hFF;
    @(negedge clk);
    jump_en = 1'b0;
    wait_en();
    wait_en();
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_halt();
    check("t4_pc", 32'(pc), 32'h1);
    end_test("t4");

    // Test 5: simultaneous halt_req and jump, then resume at the jump target
    do_reset();
    load_default();
    mem[0] = 16'h0700; mem[8'h10] = 16'h0800;
    fetch_q = '{8'h00, 8'h10, 8'h11};
    issue_q = '{16'h0700, 16'h0800};
    pulse_start();
    wait_en();
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 8'h10; halt_req = 1'b1;
    @(negedge clk);
    jump_en = 1'b0; halt_req = 1'b0;
    wait_halt();
    check("t5_pc_jump_halt", 32'(pc), 32'h10);
    repeat (4) @(negedge clk);
    check("t5_still_halted", 32'(halted), 32'h1);
    check("t5_no_fetch_in_halt", 32'(fetch_q.size()), 32'h2);
    pulse_start();
    check("t5_halt_cleared", 32'(halted), 32'h0);
    wait_halt();
    check("t5_pc_final", 32'(pc), 32'h11);
    end_test("t5");

    // Test 6: reset during WAIT, late imem_valid must be ignored
    do_reset();
    load_default();
    mem[0] = 16'h0900;
    mem_lat = 3;
    fetch_q = '{8'h00};
    issue_q.delete();
    pulse_start();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_addr_ins_ignored", 32'(addr_ins), 32'h0);
    check("t6_pc", 32'(pc), 32'h0);
    check("t6_halted", 32'(halted), 32'h0);
    mem_lat = 1;
    end_test("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
